xif_mac_copro: RTL

Minimal CORE-V-X coprocessor that answers the core's issue/commit/result transactions for custom-0 multiply-accumulate instructions. It connects to the core's X-interface in place of, or alongside, the FPU subsystem in the simple system, and holds a 32-bit architectural accumulator. One instruction is in flight at a time; the compressed and memory channels are unused and tied off by the integrator.

---
 rtl/xif_mac_pkg.sv | 17 +
 rtl/xif_mac_mul.sv | 42 ++++
 rtl/xif_mac_copro.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/xif_mac_pkg.sv
// Shared decode constants and FSM state type for the X-interface MAC coprocessor.
package xif_mac_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  localparam logic [2:0] FN_MACC   = 3'b000;
  localparam logic [2:0] FN_RDACC  = 3'b001;
  localparam logic [2:0] FN_CLRACC = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_COMMIT,
    EXEC,
    RESULT
  } state_e;

endpackage

// File: rtl/xif_mac_mul.sv
// Pipelined 32x32->32 multiplier; done_o marks the product emerging MulLatency cycles after start_i.
module xif_mac_mul #(
  parameter int unsigned MulLatency = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] prod_o
);

  logic [31:0]           prod_q [MulLatency];
  logic [31:0]           prod_d [MulLatency];
  logic [MulLatency-1:0] vld_q, vld_d;

  always_comb begin
    prod_d    = prod_q;
    vld_d     = vld_q;
    prod_d[0] = a_i * b_i;
    vld_d[0]  = start_i;
    for (int unsigned i = 1; i < MulLatency; i++) begin
      prod_d[i] = prod_q[i-1];
      vld_d[i]  = vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < MulLatency; i++) prod_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      prod_q <= prod_d;
    end
  end

  assign done_o = vld_q[MulLatency-1];
  assign prod_o = prod_q[MulLatency-1];

endmodule

// File: rtl/xif_mac_copro.sv
// CORE-V-X coprocessor executing custom-0 MACC/RDACC/CLRACC against a 32-bit accumulator,
// one instruction in flight at a time.
module xif_mac_copro
  import xif_mac_pkg::*;
#(
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned MulLatency = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [31:0]          issue_instr_i,
  input  logic [IdWidth-1:0]   issue_id_i,
  input  logic [1:0][31:0]     issue_rs_i,
  input  logic [1:0]           issue_rs_valid_i,
  output logic                 issue_accept_o,
  output logic                 issue_writeback_o,
  input  logic                 commit_valid_i,
  input  logic [IdWidth-1:0]   commit_id_i,
  input  logic                 commit_kill_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [IdWidth-1:0]   result_id_o,
  output logic [31:0]          result_data_o,
  output logic [4:0]           result_rd_o,
  output logic                 result_we_o
);

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   id_q, id_d, res_id_q, res_id_d;
  logic [4:0]           rd_q, rd_d, res_rd_q, res_rd_d;
  logic [2:0]           fn_q, fn_d;
  logic [31:0]          rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]          acc_q, acc_d, res_data_q, res_data_d;
  logic                 rst_dly_q, rst_dly_d;

  logic       dec_ok;
  logic [1:0] rs_need;
  logic       mul_start, mul_done;
  logic [31:0] mul_a, mul_b, mul_prod;
  logic       unused_instr;

  assign unused_instr = ^issue_instr_i[24:15];

  always_comb begin
    dec_ok  = 1'b0;
    rs_need = 2'b00;
    if (issue_instr_i[6:0] == OPCODE_CUSTOM0 && issue_instr_i[31:25] == 7'd0) begin
      case (issue_instr_i[14:12])
        FN_MACC: begin
          dec_ok  = 1'b1;
          rs_need = 2'b11;
        end
        FN_RDACC, FN_CLRACC: dec_ok = 1'b1;
        default: ;
      endcase
    end
  end

  // Issue side is held off during reset and for one cycle after it.
  assign issue_ready_o     = (state_q == IDLE) && !rst_i && !rst_dly_q && issue_valid_i &&
                             ((issue_rs_valid_i & rs_need) == rs_need);
  assign issue_accept_o    = issue_ready_o && dec_ok;
  assign issue_writeback_o = issue_accept_o;

  // A same-cycle commit starts the multiplier from the live operands, before they are latched.
  assign mul_a = (state_q == IDLE) ? issue_rs_i[0] : rs1_q;
  assign mul_b = (state_q == IDLE) ? issue_rs_i[1] : rs2_q;

  xif_mac_mul #(
    .MulLatency(MulLatency)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(mul_start),
    .a_i    (mul_a),
    .b_i    (mul_b),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    rd_d       = rd_q;
    fn_d       = fn_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    acc_d      = acc_q;
    res_id_d   = res_id_q;
    res_rd_d   = res_rd_q;
    res_data_d = res_data_q;
    rst_dly_d  = rst_i;
    mul_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_accept_o) begin
          id_d  = issue_id_i;
          rd_d  = issue_instr_i[11:7];
          fn_d  = issue_instr_i[14:12];
          rs1_d = issue_rs_i[0];
          rs2_d = issue_rs_i[1];
          if (commit_valid_i && commit_id_i == issue_id_i) begin
            if (!commit_kill_i) begin
              state_d   = EXEC;
              mul_start = 1'b1;
            end
          end else begin
            state_d = WAIT_COMMIT;
          end
        end
      end
      WAIT_COMMIT: begin
        if (commit_valid_i && commit_id_i == id_q) begin
          if (commit_kill_i) begin
            state_d = IDLE;
          end else begin
            state_d   = EXEC;
            mul_start = 1'b1;
          end
        end
      end
      EXEC: begin
        if (mul_done) begin
          state_d  = RESULT;
          res_id_d = id_q;
          res_rd_d = rd_q;
          case (fn_q)
            FN_MACC: begin
              acc_d      = acc_q + mul_prod;
              res_data_d = acc_q + mul_prod;
            end
            FN_CLRACC: begin
              acc_d      = '0;
              res_data_d = acc_q;
            end
            default: res_data_d = acc_q;
          endcase
        end
      end
      RESULT: begin
        if (result_ready_i) begin
          state_d    = IDLE;
          res_id_d   = '0;
          res_rd_d   = '0;
          res_data_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      id_q       <= '0;
      rd_q       <= '0;
      fn_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      acc_q      <= '0;
      res_id_q   <= '0;
      res_rd_q   <= '0;
      res_data_q <= '0;
      rst_dly_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      rd_q       <= rd_d;
      fn_q       <= fn_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      acc_q      <= acc_d;
      res_id_q   <= res_id_d;
      res_rd_q   <= res_rd_d;
      res_data_q <= res_data_d;
      rst_dly_q  <= rst_dly_d;
    end
  end

  assign result_valid_o = (state_q == RESULT);
  assign result_we_o    = (state_q == RESULT);
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_data_o  = res_data_q;

endmodule
